// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: PC feedback, instruction-memory read port, redirect and decode handshake.
`timescale 1ns/1ps
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_result;
  logic [31:0]   address;
  logic [31:0]   imem_addr;
  logic          imem_read_en;
  logic [31:0]   imem_data;
  logic          redirect;
  logic [31:0]   redirect_target;
  logic [31:0]   instr_out;
  logic [31:0]   instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [CW-1:0] count;

  // master: the fetch queue itself; slave: PC, memory and decode around it
  modport master (
    input  pc_result, imem_data, redirect, redirect_target, instr_ready,
    output address, imem_addr, imem_read_en, instr_out, instr_pc, instr_valid, count
  );
  modport slave (
    output pc_result, imem_data, redirect, redirect_target, instr_ready,
    input  address, imem_addr, imem_read_en, instr_out, instr_pc, instr_valid, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-based issue to a 1-cycle memory, PC-tagged FIFO, redirect/flush.
// Optional same-cycle bypass of an arriving response into an empty queue: define FETCH_BYPASS_EN.
`timescale 1ns/1ps
module fetch_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master fq
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state_q, state_d;
  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          inflight_q, squash_q;
  logic [31:0]   issue_pc_q;
  entry_t        hold_q;

  logic   issue, resp_ok, fifo_empty, bypass, valid, push, fifo_pop;
  entry_t resp, disp;

  // Next state, issue decision, head selection and handshake
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    fifo_empty = (count_q == '0);
    resp       = '{pc: issue_pc_q, instr: fq.imem_data};
    resp_ok    = inflight_q & ~squash_q & ~fq.redirect;
`ifdef FETCH_BYPASS_EN
    bypass     = fifo_empty & resp_ok;
`else
    bypass     = 1'b0;
`endif
    case (state_q)
      BOOT: state_d = RUN;
      RUN:  issue = ~fq.redirect & (CW'(count_q + CW'(inflight_q)) < CW'(DEPTH));
      default: state_d = BOOT;
    endcase

    if (!reset)           fq.address = RESET_VECTOR;
    else if (fq.redirect) fq.address = fq.redirect_target;
    else if (issue)       fq.address = fq.pc_result + 32'(PC_STEP);
    else                  fq.address = fq.pc_result;

    if (!fifo_empty)  disp = mem[rd_ptr_q];
    else if (bypass)  disp = resp;
    else              disp = hold_q;

    valid    = (~fifo_empty | bypass) & ~fq.redirect;
    fifo_pop = valid & fq.instr_ready & ~fifo_empty;
    // A bypassed response taken by decode this cycle never lands in storage
    push     = resp_ok & ~(bypass & fq.instr_ready);

    fq.imem_read_en = issue;
    fq.imem_addr    = fq.pc_result;
    fq.instr_valid  = valid;
    fq.instr_out    = disp.instr;
    fq.instr_pc     = disp.pc;
    fq.count        = count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
      issue_pc_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      squash_q   <= fq.redirect & inflight_q;
      hold_q     <= disp;
      if (issue) issue_pc_q <= fq.pc_result;
      if (fq.redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (fifo_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        if (push)     wr_ptr_q <= wr_ptr_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(fifo_pop);
      end
    end
  end

  // Storage needs no reset: occupancy gates every read of it
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= resp;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed checks plus randomized traffic against a queue-level model.
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_VECTOR(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk),
    .reset(reset),
    .fq(fq.master)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Environment: PC register fed by Address, synchronous instruction memory
  always @(posedge clk or negedge reset) begin
    if (!reset) fq.pc_result <= 32'h0;
    else        fq.pc_result <= fq.address;
  end

  always @(posedge clk) begin
    if (fq.imem_read_en) fq.imem_data <= mem_fn(fq.imem_addr);
    else                 fq.imem_data <= $urandom();
  end

  // Reference model: queue of tagged instructions plus one outstanding read
  ent_t        q[$];
  bit          pend, sq, boot;
  logic [31:0] pend_pc;
  ent_t        last;

  always @(negedge clk) begin
    int          n;
    bit          byp, iss, vld, arrive;
    logic [31:0] exp_addr;
    ent_t        disp;
    if (!reset) begin
      check32("rst_address", fq.address, 32'h0);
      check32("rst_read_en", 32'(fq.imem_read_en), 32'h0);
      check32("rst_valid", 32'(fq.instr_valid), 32'h0);
      check32("rst_count", 32'(fq.count), 32'h0);
      check32("rst_instr_out", fq.instr_out, 32'h0);
      check32("rst_instr_pc", fq.instr_pc, 32'h0);
      q.delete();
      pend = 0;
      sq   = 0;
      boot = 1;
      last = '{pc: 32'h0, instr: 32'h0};
    end else begin
      n = q.size();
`ifdef FETCH_BYPASS_EN
      byp = (n == 0) && pend && !sq && !fq.redirect;
`else
      byp = 0;
`endif
      iss = !boot && !fq.redirect && (n + int'(pend) < int'(DEPTH));
      exp_addr = fq.redirect ? fq.redirect_target : (iss ? fq.pc_result + 32'd4 : fq.pc_result);
      if (n > 0)    disp = q[0];
      else if (byp) disp = '{pc: pend_pc, instr: mem_fn(pend_pc)};
      else          disp = last;
      vld = (n > 0 || byp) && !fq.redirect;

      check32("read_en", 32'(fq.imem_read_en), 32'(iss));
      check32("address", fq.address, exp_addr);
      check32("count", 32'(fq.count), 32'(n));
      check32("valid", 32'(fq.instr_valid), 32'(vld));
      check32("instr_out", fq.instr_out, disp.instr);
      check32("instr_pc", fq.instr_pc, disp.pc);
      if (iss) check32("imem_addr", fq.imem_addr, fq.pc_result);

      last = disp;
      if (fq.redirect) begin
        q.delete();
        sq   = pend;
        pend = 0;
      end else begin
        arrive = pend && !sq;
        if (vld && fq.instr_ready) begin
          if (n > 0) void'(q.pop_front());
          else       arrive = 0;
        end
        if (arrive) q.push_back('{pc: pend_pc, instr: mem_fn(pend_pc)});
        check32("no_overflow", 32'(q.size() <= int'(DEPTH)), 32'h1);
        sq   = 0;
        pend = iss;
        if (iss) pend_pc = fq.pc_result;
      end
      boot = 0;
    end
  end

  // Advance to just after the next rising edge; inputs change here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit hit;
    int ready_pct;
    fq.redirect        = 1'b0;
    fq.redirect_target = 32'h0;
    fq.instr_ready     = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // BOOT cycle: no read, Address follows PCResult
    #1;
    check32("boot_read_en", 32'(fq.imem_read_en), 32'h0);
    check32("boot_address", fq.address, 32'h0);
    step(); #1;
    check32("first_issue_en", 32'(fq.imem_read_en), 32'h1);
    check32("first_issue_addr", fq.imem_addr, 32'h0);
    check32("first_next_pc", fq.address, 32'h4);

    // Fill with decode stalled
    repeat (6) step();
    #1;
    check32("full_count", 32'(fq.count), 32'd4);
    check32("full_no_read", 32'(fq.imem_read_en), 32'h0);
    check32("full_pc_hold", fq.address, 32'h10);
    check32("full_head_pc", fq.instr_pc, 32'h0);
    check32("full_head_instr", fq.instr_out, 32'h1357_6420);

    // One pop frees exactly one credit
    step(); fq.instr_ready = 1'b1;
    step(); fq.instr_ready = 1'b0;
    #1;
    check32("refill_en", 32'(fq.imem_read_en), 32'h1);
    check32("refill_addr", fq.imem_addr, 32'h10);
    check32("after_pop_count", 32'(fq.count), 32'd3);
    step(); #1;
    check32("refill_single", 32'(fq.imem_read_en), 32'h0);
    check32("new_head_pc", fq.instr_pc, 32'h4);
    check32("new_head_instr", fq.instr_out, 32'h1353_6420);

    // Redirect flushes and refetches from the target
    step(); fq.redirect = 1'b1; fq.redirect_target = 32'h40; fq.instr_ready = 1'b1;
    #1;
    check32("redir_address", fq.address, 32'h40);
    check32("redir_valid", 32'(fq.instr_valid), 32'h0);
    check32("redir_read_en", 32'(fq.imem_read_en), 32'h0);
    step(); fq.redirect = 1'b0;
    #1;
    check32("flush_count", 32'(fq.count), 32'h0);
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      if (fq.instr_valid) begin
        hit = 1;
        break;
      end
      step(); #1;
    end
    check32("redir_wait", 32'(hit), 32'h1);
    check32("redir_first_pc", fq.instr_pc, 32'h40);

    // Address wraps past the top of the 32-bit space
    step(); fq.redirect = 1'b1; fq.redirect_target = 32'hFFFF_FFFC;
    step(); fq.redirect = 1'b0;
    #1;
    check32("wrap_issue_addr", fq.imem_addr, 32'hFFFF_FFFC);
    check32("wrap_next_pc", fq.address, 32'h0);

    // Async reset while three entries are queued
    step(); fq.redirect = 1'b1; fq.redirect_target = 32'h100; fq.instr_ready = 1'b0;
    step(); fq.redirect = 1'b0;
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (fq.count == 3) begin
        hit = 1;
        break;
      end
      step();
    end
    check32("reach_count3", 32'(hit), 32'h1);
    #1 reset = 1'b0;
    #1;
    check32("async_count", 32'(fq.count), 32'h0);
    check32("async_valid", 32'(fq.instr_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Randomized traffic against the model
    ready_pct = 50;
    for (int c = 0; c < 2400; c++) begin
      step();
      if (c % 200 == 0) ready_pct = $urandom_range(100);
      fq.instr_ready = ($urandom_range(99) < ready_pct);
      fq.redirect    = ($urandom_range(15) == 0);
      if ($urandom_range(3) == 0) fq.redirect_target = 32'hFFFF_FFF0 | ($urandom() & 32'hC);
      else                        fq.redirect_target = $urandom() & 32'hFFFF_FFFC;
    end
    step();
    fq.redirect    = 1'b0;
    fq.instr_ready = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end that sits on the far side of the program counter register.
- Consumes the PC's current value (PCResult) and drives the PC's next value (Address).
- Issues reads to a synchronous instruction memory and buffers the returned instructions, each paired with its PC, in a small FIFO.
- Hands instructions to decode with a valid/ready handshake; supports redirect (branch/jump) with flush and squash of in-flight reads.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
RESET_VECTOR, 32'h0000_0000, value driven on Address while Reset is asserted
PC_STEP, 4, byte increment per sequential fetch

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset (0 = reset)
PCResult  input  32  current PC from ProgramCounter
Address  output  32  next PC into ProgramCounter
IMemAddr  output  32  instruction memory read address
IMemReadEn  output  1  read strobe; data returns exactly 1 cycle later
IMemData  input  32  read data, valid the cycle after IMemReadEn
Redirect  input  1  one-cycle pulse: flush and refetch from RedirectTarget
RedirectTarget  input  32  new fetch PC, word aligned
InstrOut  output  32  head instruction
InstrPC  output  32  PC of head instruction
InstrValid  output  1  head entry valid
InstrReady  input  1  decode accepts head when InstrValid=1
Count  output  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset low (async):
  - FSM=BOOT; FIFO empty; Count=0; in-flight flag cleared; squash flag cleared.
  - IMemReadEn=0; InstrValid=0; InstrOut=0; InstrPC=0; Address=RESET_VECTOR.
- FSM states:
  - BOOT: first cycle after Reset deasserts. No issue; Address=PCResult. Goes to RUN unconditionally.
  - RUN: normal operation.
- Issue rule (RUN, Redirect=0): issue when Count + inflight < DEPTH. Pops in the same cycle do not count toward this (conservative).
  - On issue: IMemReadEn=1, IMemAddr=PCResult, Address=PCResult+PC_STEP (32-bit wrap: 32'hFFFF_FFFC -> 0), inflight<=1.
  - No issue: IMemReadEn=0, Address=PCResult (hold).
- Response: in the cycle after an issue, if inflight=1 and squash=0, push {PCResult_at_issue, IMemData} at the clock edge. Without the optional feature, it becomes visible as InstrValid the following cycle (issue N -> InstrValid N+2).
- Pop: when InstrValid & InstrReady, the head is removed at the clock edge. Push and pop in the same cycle leave Count unchanged.
- Full (Count=DEPTH): no issue, Address holds, PC stalls. Empty: InstrValid=0; InstrOut/InstrPC hold their last values.
- Redirect=1 (RUN or BOOT):
  - Address=RedirectTarget; IMemReadEn=0; InstrValid forced 0 that cycle, so no pop occurs.
  - FIFO flushed (Count<=0).
  - If a read is in flight, squash<=1: that response is discarded next cycle and squash clears.
  - Redirect wins over issue, push and pop in the same cycle.
- Pointers wrap modulo DEPTH; Count never exceeds DEPTH. An overflow push is impossible by the credit rule and is an assertion failure in verification.
- Reset mid-operation: all state is cleared immediately; any memory response arriving after Reset deasserts is ignored.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the FIFO is empty and a non-squashed response arrives, IMemData/issue PC drive InstrOut/InstrPC directly with InstrValid=1 in that same cycle.
  - If InstrReady=1, the entry is consumed and not written.
  - Otherwise it is pushed as normal.
  - Latency issue N -> InstrValid N+1.
- Undefined: no bypass; latency N+2; InstrOut/InstrPC are driven only from FIFO storage.

Test Plan:
- Reset low for 3 cycles, then release with PCResult fed back from a PC model (reset 0) -> Address=0 during reset. BOOT cycle has no read; fetches then issue at 0,4,8,...; InstrPC sequence 0,4,8 with matching IMemData.
- InstrReady=0 held, DEPTH=4 -> exactly 4 reads issue; Count=4; IMemReadEn=0 and Address=PCResult (0x10) thereafter. One InstrReady pulse -> one pop, and exactly one new read at 0x10.
- Redirect pulse to 0x40 while Count=2 and a read to 0x0C is in flight -> Count=0 next cycle; the 0x0C response is dropped. Next accepted InstrPC=0x40.
- Simultaneous push and pop with Count=2 -> Count stays 2; FIFO order preserved (head PC increments by 4).
- PCResult=32'hFFFF_FFFC on an issue -> Address=0x0000_0000.
- Reset asserted mid-stream with Count=3 -> InstrValid=0 and Count=0 immediately (async); a stale IMemData response after release is not pushed.
